// File: rtl/control_unit.sv
// control_unit -- registered main decoder for a single-issue MIPS-style core.
//
// Decodes the 6-bit instruction opcode into datapath control strobes. Every
// output comes straight from a flop, so outputs reflect the OpCode sampled at
// the previous rising clk edge and there is no combinational input-to-output
// path.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset (outputs -> NOP, IllegalOp=0)
//   Flush      in   loads NOP with IllegalOp=0 on the next edge
//   OpCode     in   [5:0] instruction bits [31:26]
//   RegDst     out  1 = write register is rd, 0 = rt
//   ALUSrc     out  1 = ALU operand B is the sign-extended immediate
//   MemtoReg   out  1 = write-back data comes from memory
//   RegWrite   out  register-file write enable
//   MemRead    out  data-memory read enable
//   MemWrite   out  data-memory write enable
//   Branch     out  conditional branch
//   ALUOp      out  [2:0] ALU operation class
//   IllegalOp  out  opcode not in the decode table
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       Flush,
  input  logic [5:0] OpCode,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Branch,
  output logic [2:0] ALUOp,
  output logic       IllegalOp
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_SLTI  = 6'b001010,
    OP_ANDI  = 6'b001100,
    OP_ORI   = 6'b001101,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_RTYPE = 3'b010,
    ALU_AND   = 3'b011,
    ALU_OR    = 3'b100,
    ALU_SLT   = 3'b101,
    ALU_BNE   = 3'b110
  } aluop_e;

  typedef struct packed {
    logic       regDst;
    logic       aluSrc;
    logic       memtoReg;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic [2:0] aluOp;
    logic       illegalOp;
  } ctrl_t;

  ctrl_t decodeD;
  ctrl_t ctrlQ;

  // Next-cycle control word; anything unlisted stays at the all-zero NOP.
  always_comb begin
    decodeD = '0;
    case (OpCode)
      OP_RTYPE: begin
        decodeD.regDst   = 1'b1;
        decodeD.regWrite = 1'b1;
        decodeD.aluOp    = ALU_RTYPE;
      end
      OP_LW: begin
        decodeD.aluSrc   = 1'b1;
        decodeD.memtoReg = 1'b1;
        decodeD.regWrite = 1'b1;
        decodeD.memRead  = 1'b1;
        decodeD.aluOp    = ALU_ADD;
      end
      OP_SW: begin
        decodeD.aluSrc   = 1'b1;
        decodeD.memWrite = 1'b1;
        decodeD.aluOp    = ALU_ADD;
      end
      OP_BEQ: begin
        decodeD.branch = 1'b1;
        decodeD.aluOp  = ALU_SUB;
      end
      OP_BNE: begin
        decodeD.branch = 1'b1;
        decodeD.aluOp  = ALU_BNE;
      end
      OP_ADDI: begin
        decodeD.aluSrc   = 1'b1;
        decodeD.regWrite = 1'b1;
        decodeD.aluOp    = ALU_ADD;
      end
      OP_SLTI: begin
        decodeD.aluSrc   = 1'b1;
        decodeD.regWrite = 1'b1;
        decodeD.aluOp    = ALU_SLT;
      end
      OP_ANDI: begin
        decodeD.aluSrc   = 1'b1;
        decodeD.regWrite = 1'b1;
        decodeD.aluOp    = ALU_AND;
      end
      OP_ORI: begin
        decodeD.aluSrc   = 1'b1;
        decodeD.regWrite = 1'b1;
        decodeD.aluOp    = ALU_OR;
      end
      default: begin
        decodeD.illegalOp = 1'b1;
      end
    endcase
  end

  // Reset and Flush both load the plain NOP (IllegalOp=0); reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrlQ <= '0;
    end else if (Flush) begin
      ctrlQ <= '0;
    end else begin
      ctrlQ <= decodeD;
    end
  end

  assign RegDst    = ctrlQ.regDst;
  assign ALUSrc    = ctrlQ.aluSrc;
  assign MemtoReg  = ctrlQ.memtoReg;
  assign RegWrite  = ctrlQ.regWrite;
  assign MemRead   = ctrlQ.memRead;
  assign MemWrite  = ctrlQ.memWrite;
  assign Branch    = ctrlQ.branch;
  assign ALUOp     = ctrlQ.aluOp;
  assign IllegalOp = ctrlQ.illegalOp;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit -- scoreboard bench for control_unit.
// Stimulus is applied on the falling edge and the expected control word is
// queued; a monitor pops and compares after each rising edge, then compares
// again after the inputs have been disturbed mid-cycle to show the outputs
// hold until the next edge.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       Flush;
  logic [5:0] OpCode;
  logic       RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic [2:0] ALUOp;
  logic       IllegalOp;

  control_unit dut (
    .clk      (clk),
    .rst      (rst),
    .Flush    (Flush),
    .OpCode   (OpCode),
    .RegDst   (RegDst),
    .ALUSrc   (ALUSrc),
    .MemtoReg (MemtoReg),
    .RegWrite (RegWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Branch   (Branch),
    .ALUOp    (ALUOp),
    .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  // Control word layout: {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp[2:0],IllegalOp}
  logic [10:0] refTable [64];
  logic [10:0] expQ [$];
  logic [5:0]  legalOps [9];
  int          nChecks = 0;
  int          nFails  = 0;

  function automatic logic [10:0] word(input logic rd, as, m2r, rw, mr, mw, br,
                                       input logic [2:0] alu);
    return {rd, as, m2r, rw, mr, mw, br, alu, 1'b0};
  endfunction

  function automatic logic [10:0] refModel(input logic r, input logic f, input logic [5:0] op);
    if (r || f) return 11'd0;
    return refTable[op];
  endfunction

  function automatic logic [10:0] dutWord();
    return {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, IllegalOp};
  endfunction

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s t=%0t got=%b expected=%b", name, $time, got, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic got, input logic exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s t=%0t got=%b expected=%b", name, $time, got, exp);
    end
  endtask

  // One cycle: drive at the falling edge, queue expectation, then scramble
  // OpCode/Flush shortly after the rising edge.
  task automatic step(input logic r, input logic f, input logic [5:0] op);
    @(negedge clk);
    rst    = r;
    Flush  = f;
    OpCode = op;
    expQ.push_back(refModel(r, f, op));
    @(posedge clk);
    #2;
    OpCode = 6'($urandom);
    Flush  = 1'($urandom);
  endtask

  always @(posedge clk) begin
    logic [10:0] e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      check("decode", dutWord(), e);
      checkBit("memRdWrExclusive", MemRead & MemWrite, 1'b0);
      checkBit("noWriteOnStoreBranch", (MemWrite | Branch) & RegWrite, 1'b0);
      #3;
      check("holdBetweenEdges", dutWord(), e);
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) refTable[i] = 11'b000_0000_000_1;
    refTable[6'b000000] = word(1, 0, 0, 1, 0, 0, 0, 3'b010);
    refTable[6'b100011] = word(0, 1, 1, 1, 1, 0, 0, 3'b000);
    refTable[6'b101011] = word(0, 1, 0, 0, 0, 1, 0, 3'b000);
    refTable[6'b000100] = word(0, 0, 0, 0, 0, 0, 1, 3'b001);
    refTable[6'b000101] = word(0, 0, 0, 0, 0, 0, 1, 3'b110);
    refTable[6'b001000] = word(0, 1, 0, 1, 0, 0, 0, 3'b000);
    refTable[6'b001010] = word(0, 1, 0, 1, 0, 0, 0, 3'b101);
    refTable[6'b001100] = word(0, 1, 0, 1, 0, 0, 0, 3'b011);
    refTable[6'b001101] = word(0, 1, 0, 1, 0, 0, 0, 3'b100);
    legalOps = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                 6'b001000, 6'b001010, 6'b001100, 6'b001101};

    rst = 1'b1; Flush = 1'b0; OpCode = 6'b000000;

    // Directed sequence
    step(1, 0, 6'b000000);
    step(1, 0, 6'b000000);
    step(0, 0, 6'b000000);   // R-type
    step(0, 0, 6'b000101);   // BNE
    step(0, 0, 6'b000110);   // illegal
    step(0, 0, 6'b111111);   // illegal
    step(0, 0, 6'b100011);   // LW
    step(0, 0, 6'b101011);   // SW
    step(0, 1, 6'b000000);   // flush
    step(1, 1, 6'b000000);   // reset + flush
    step(0, 0, 6'b000100);   // BEQ
    step(1, 0, 6'b100011);   // reset discards pending LW
    step(0, 0, 6'b001101);   // ORI

    // Randomized sequence
    for (int n = 0; n < 400; n++) begin
      logic       r, f;
      logic [5:0] op;
      r  = ($urandom_range(15) == 0);
      f  = ($urandom_range(7) == 0);
      op = ($urandom_range(1) == 0) ? legalOps[$urandom_range(8)] : 6'($urandom);
      step(r, f, op);
    end

    repeat (3) @(negedge clk);
    checkBit("scoreboardDrained", expQ.size() == 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL provide ports: clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL provide: rst  in  1  synchronous, active-high reset; sampled on rising clk edge only.
REQ-003 SHALL provide: Flush  in  1  forces a NOP decode on the next edge.
REQ-004 SHALL provide: OpCode  in  6  instruction opcode, instruction bits [31:26].
REQ-005 SHALL provide: RegDst  out  1  1 = write-register is rd; 0 = rt.
REQ-006 SHALL provide: ALUSrc  out  1  1 = ALU operand B is the sign-extended immediate.
REQ-007 SHALL provide: MemtoReg  out  1  1 = register write-back data comes from memory.
REQ-008 SHALL provide: RegWrite  out  1  register-file write enable.
REQ-009 SHALL provide: MemRead  out  1  data-memory read enable.
REQ-010 SHALL provide: MemWrite  out  1  data-memory write enable.
REQ-011 SHALL provide: Branch  out  1  conditional branch instruction.
REQ-012 SHALL provide: ALUOp  out  3  ALU operation class.
REQ-013 SHALL provide: IllegalOp  out  1  1 = opcode not in the decode table.

Function
REQ-014 SHALL register all outputs; latency is one clock, so outputs reflect the OpCode sampled at the previous rising edge.
REQ-015 SHALL decode as follows; fields not listed SHALL be 0:
  - R-type 000000: RegDst=1, RegWrite=1, ALUOp=010.
  - LW 100011: ALUSrc=1, MemtoReg=1, RegWrite=1, MemRead=1, ALUOp=000.
  - SW 101011: ALUSrc=1, MemWrite=1, ALUOp=000.
  - BEQ 000100: Branch=1, ALUOp=001.
  - BNE 000101: Branch=1, ALUOp=110.
  - ADDI 001000: ALUSrc=1, RegWrite=1, ALUOp=000.
  - SLTI 001010: ALUSrc=1, RegWrite=1, ALUOp=101.
  - ANDI 001100: ALUSrc=1, RegWrite=1, ALUOp=011.
  - ORI 001101: ALUSrc=1, RegWrite=1, ALUOp=100.
REQ-016 Any other opcode (including 000110 and 111111) SHALL produce the NOP pattern (all control outputs 0, ALUOp=000) with IllegalOp=1.
REQ-017 At most one of MemRead or MemWrite SHALL be 1 in any cycle.
REQ-018 MemWrite=1 or Branch=1 SHALL imply RegWrite=0.
REQ-019 A Flush high at a rising edge SHALL load the NOP pattern with IllegalOp=0, regardless of OpCode.
REQ-020 Precedence at a rising edge SHALL be rst, then Flush, then normal decode.
REQ-021 A change of OpCode between edges SHALL NOT affect outputs until the next rising edge; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-022 With rst high at a rising edge, all outputs SHALL become 0 (NOP, IllegalOp=0) on that edge.
REQ-023 Outputs SHALL remain 0 for every cycle rst stays high.
REQ-024 The first decode SHALL appear one edge after the first edge with rst low.
REQ-025 Reset asserted mid-sequence SHALL discard the pending decode, with no partial update.
REQ-026 Outputs are undefined before the first reset edge.

Verification
REQ-027 rst=1 for 2 edges, OpCode=000000 -> all outputs 0; after release, the next edge gives RegDst=1, RegWrite=1, ALUOp=010, others 0.
REQ-028 OpCode=000101 -> after one edge: Branch=1, ALUOp=110, RegWrite=0, IllegalOp=0.
REQ-029 OpCode=000110, then 111111 -> after each edge: all control outputs 0, ALUOp=000, IllegalOp=1.
REQ-030 OpCode 100011 then 101011 on consecutive edges -> LW pattern (MemRead=1, MemtoReg=1) then SW pattern (MemWrite=1, RegWrite=0).
REQ-031 OpCode=000000 with Flush=1 -> NOP with IllegalOp=0; with rst=1 and Flush=1 together -> all outputs 0.
REQ-032 OpCode toggled between edges -> outputs are unchanged until the next rising edge.
